// File: rtl/lbp_ctrl_if.sv
// Bus between the LBP sequencer and its surroundings: grayscale read port,
// LBP write port, position counter handshake and start/finish status.
interface lbp_ctrl_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              gray_ready;
    logic [ADDR_W-1:0] pos;
    logic              cnt_en;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [7:0]        gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;

    modport master (
        input  gray_ready, pos, gray_data,
        output cnt_en, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, pos, gray_data,
        input  cnt_en, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp_ctrl.sv
// LBP sequencer: fetches each interior 3x3 window, forms the 8-bit LBP code and writes it.
// Optional macro LBP_SLIDING_WINDOW_EN reuses two window columns and fetches only the right one.
module lbp_ctrl #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned ADDR_W = 14
) (
    input  logic       clk,
    input  logic       reset,
    lbp_ctrl_if.master bus
);
    localparam int unsigned       XW         = ADDR_W / 2;
    localparam logic [XW-1:0]     X_FIRST    = XW'(1);
    localparam logic [ADDR_W-1:0] LAST_POS   = ADDR_W'((IMG_W - 2) * IMG_W + (IMG_W - 2));
    localparam logic [ADDR_W-1:0] ORIGIN_OFF = ADDR_W'(IMG_W + 1);

    typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        k, k_nxt;
    logic [7:0]        win [9];
    logic [7:0]        code;
    logic [7:0]        lbp_data_q;
    logic              slide;
    logic [3:0]        k_last;
    logic [1:0]        rd_row, rd_col;
    logic [3:0]        cap_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              gray_req, lbp_valid, cnt_en, finish;
    logic [ADDR_W-1:0] gray_addr, lbp_addr;

`ifdef LBP_SLIDING_WINDOW_EN
    // Only a row-start centre lacks a reusable left/middle column.
    assign slide = (bus.pos[XW-1:0] != X_FIRST);
`else
    assign slide = 1'b0;
`endif

    // Read/capture mapping for the current fetch index.
    always_comb begin
        k_last  = slide ? 4'd3 : 4'd9;
        rd_row  = slide ? 2'(k) : 2'(k / 4'd3);
        rd_col  = slide ? 2'd2  : 2'(k % 4'd3);
        rd_addr = bus.pos + (ADDR_W'(rd_row) << XW) + ADDR_W'(rd_col) - ORIGIN_OFF;
        cap_idx = k - 4'd1;
        if (slide) begin
            case (k)
                4'd1:    cap_idx = 4'd2;
                4'd2:    cap_idx = 4'd5;
                default: cap_idx = 4'd8;
            endcase
        end
    end

    assign code = {win[8] >= win[4], win[7] >= win[4], win[6] >= win[4], win[5] >= win[4],
                   win[3] >= win[4], win[2] >= win[4], win[1] >= win[4], win[0] >= win[4]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and bus strobes.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        gray_req  = 1'b0;
        gray_addr = '0;
        lbp_valid = 1'b0;
        lbp_addr  = '0;
        cnt_en    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.gray_ready) begin
                    state_nxt = FETCH;
                    k_nxt     = '0;
                end
            end
            FETCH: begin
                if (k != k_last) begin
                    gray_req  = 1'b1;
                    gray_addr = rd_addr;
                    k_nxt     = k + 4'd1;
                end else begin
                    state_nxt = CALC;
                    k_nxt     = '0;
                end
            end
            CALC: state_nxt = WRITE;
            WRITE: begin
                lbp_valid = 1'b1;
                lbp_addr  = bus.pos;
                if (bus.pos == LAST_POS) begin
                    state_nxt = DONE;
                end else begin
                    cnt_en    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DONE:    finish = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch index, window capture and code register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k          <= '0;
            lbp_data_q <= '0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            k <= k_nxt;
            if (state == FETCH) begin
                if (k == 4'd0 && slide) begin
                    win[0] <= win[1];
                    win[1] <= win[2];
                    win[3] <= win[4];
                    win[4] <= win[5];
                    win[6] <= win[7];
                    win[7] <= win[8];
                end
                if (k != 4'd0) win[cap_idx] <= bus.gray_data;
            end
            if (state == CALC) lbp_data_q <= code;
        end
    end

    assign bus.gray_req  = gray_req;
    assign bus.gray_addr = gray_addr;
    assign bus.lbp_valid = lbp_valid;
    assign bus.lbp_addr  = lbp_addr;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.cnt_en    = cnt_en;
    assign bus.finish    = finish;
endmodule

// File: tb/tb_lbp_ctrl.sv
// Bench for lbp_ctrl: position counter, registered grayscale memory and an LBP reference model.
module tb_lbp_ctrl;
    localparam int unsigned IMG_W  = 128;
    localparam int unsigned ADDR_W = 14;
    localparam int          NPIX   = IMG_W * IMG_W;
    localparam int          LAST   = IMG_W - 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       load  = 1'b0;
    int         load_y = 1, load_x = 1;
    int         py, px;
    logic [7:0] mem [NPIX];
    int         errors = 0, checks = 0;

    lbp_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lbp_ctrl #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Position counter; load lets a run start deep in the frame.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            py <= 1; px <= 1;
        end else if (load) begin
            py <= load_y; px <= load_x;
        end else if (bus.cnt_en) begin
            if (px == LAST) begin px <= 1; py <= py + 1; end
            else px <= px + 1;
        end
    end
    assign bus.pos = ADDR_W'(py * IMG_W + px);

    always @(posedge clk) if (bus.gray_req) bus.gray_data <= mem[bus.gray_addr];

    function automatic logic [7:0] ref_code(input int c);
        int y = c / IMG_W, x = c % IMG_W, b = 0;
        logic [7:0] r = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (dy != 0 || dx != 0) begin
                    r[b] = mem[(y + dy) * IMG_W + x + dx] >= mem[c];
                    b++;
                end
        return r;
    endfunction

    function automatic bit slides(input int x);
`ifdef LBP_SLIDING_WINDOW_EN
        return x != 1;
`else
        return (x < 0);
`endif
    endfunction

    task automatic fill_random(input int hi);
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, hi));
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1; bus.gray_ready = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    // Returns at the negedge of the first FETCH cycle, gray_ready already dropped.
    task automatic start_at(input int y, input int x);
        @(negedge clk); load_y = y; load_x = x; load = 1'b1;
        @(negedge clk); load = 1'b0; bus.gray_ready = 1'b1;
        @(negedge clk); bus.gray_ready = 1'b0;
    endtask

    task automatic wait_write(input int limit, output bit ok, output int cyc);
        ok = 1'b0;
        for (cyc = 0; cyc < limit; cyc++) begin
            if (bus.lbp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int busy = 0;
        reset = 1'b1; bus.gray_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.gray_req, bus.lbp_valid, bus.cnt_en, bus.finish, bus.gray_addr, bus.lbp_addr, bus.lbp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b val=%b cnt=%b fin=%b ga=%0d la=%0d ld=%h, want all 0",
                     bus.gray_req, bus.lbp_valid, bus.cnt_en, bus.finish, bus.gray_addr, bus.lbp_addr, bus.lbp_data);
        end
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.gray_req || bus.lbp_valid || bus.cnt_en || bus.finish) busy++;
        end
        checks++;
        if (busy != 0) begin errors++; $display("FAIL idle_without_ready: active cycles=%0d want 0", busy); end
    endtask

    task automatic test_first_centre();
        fill_random(255);
        apply_reset();
        start_at(1, 1);
        for (int c = 0; c < 12; c++) begin
            bit ereq = (c < 9);
            int ea   = (IMG_W + 1) + (c / 3 - 1) * IMG_W + (c % 3 - 1);
            checks++;
            if (bus.gray_req !== ereq) begin errors++; $display("FAIL first_req c=%0d: got %b want %b", c, bus.gray_req, ereq); end
            if (ereq) begin
                checks++;
                if (bus.gray_addr !== ADDR_W'(ea)) begin errors++; $display("FAIL first_addr c=%0d: got %0d want %0d", c, bus.gray_addr, ea); end
            end
            checks++;
            if (bus.lbp_valid !== (c == 11)) begin errors++; $display("FAIL first_valid c=%0d: got %b want %b", c, bus.lbp_valid, c == 11); end
            if (c == 11) begin
                checks++;
                if (bus.lbp_addr !== ADDR_W'(IMG_W + 1)) begin errors++; $display("FAIL first_lbp_addr: got %0d want %0d", bus.lbp_addr, IMG_W + 1); end
                checks++;
                if (bus.lbp_data !== ref_code(IMG_W + 1)) begin errors++; $display("FAIL first_code: got %h want %h", bus.lbp_data, ref_code(IMG_W + 1)); end
                checks++;
                if (bus.cnt_en !== 1'b1) begin errors++; $display("FAIL first_cnt_en: got %b want 1", bus.cnt_en); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_patterns();
        for (int p = 0; p < 6; p++) begin
            logic [7:0] want;
            bit ok;
            int cyc;
            fill_random(255);
            for (int i = 0; i < 9; i++) begin
                int a = (i / 3) * IMG_W + i % 3;
                int j = (i < 4) ? i : i - 1;
                if (p == 0)      mem[a] = 8'd50;
                else if (p == 1) mem[a] = (i == 4) ? 8'd50 : ((j % 2 == 1) ? 8'd60 : 8'd10);
                else             mem[a] = 8'($urandom_range(0, 3));
            end
            want = (p == 0) ? 8'hFF : (p == 1) ? 8'hAA : ref_code(IMG_W + 1);
            apply_reset();
            start_at(1, 1);
            wait_write(30, ok, cyc);
            checks++;
            if (!ok) begin errors++; $display("FAIL pattern%0d_timeout: no write in %0d cycles", p, cyc); end
            checks++;
            if (bus.lbp_data !== want) begin errors++; $display("FAIL pattern%0d_code: got %h want %h", p, bus.lbp_data, want); end
        end
    endtask

    task automatic test_reset_mid();
        int  busy = 0, cyc;
        bit  ok;
        fill_random(255);
        apply_reset();
        start_at(5, 7);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.gray_req !== 1'b1) begin errors++; $display("FAIL mid_fetch_req: got %b want 1", bus.gray_req); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.gray_req, bus.lbp_valid, bus.cnt_en, bus.finish, bus.gray_addr, bus.lbp_addr, bus.lbp_data} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got req=%b val=%b cnt=%b fin=%b ga=%0d la=%0d ld=%h, want all 0",
                     bus.gray_req, bus.lbp_valid, bus.cnt_en, bus.finish, bus.gray_addr, bus.lbp_addr, bus.lbp_data);
        end
        @(negedge clk); reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.gray_req || bus.lbp_valid || bus.cnt_en) busy++;
        end
        checks++;
        if (busy != 0) begin errors++; $display("FAIL post_reset_idle: active cycles=%0d want 0", busy); end
        bus.gray_ready = 1'b1;
        @(negedge clk); bus.gray_ready = 1'b0;
        wait_write(40, ok, cyc);
        checks++;
        if (!ok || cyc != 11) begin errors++; $display("FAIL restart_latency: got ok=%b cyc=%0d want cyc=11", ok, cyc); end
        checks++;
        if (bus.lbp_addr !== ADDR_W'(IMG_W + 1)) begin errors++; $display("FAIL restart_addr: got %0d want %0d", bus.lbp_addr, IMG_W + 1); end
        checks++;
        if (bus.lbp_data !== ref_code(IMG_W + 1)) begin errors++; $display("FAIL restart_code: got %h want %h", bus.lbp_data, ref_code(IMG_W + 1)); end
    endtask

    task automatic test_full_frame(input int y0);
        int exp_q[$];
        int n = 0, exp_total = 0, exp_reads = 0;
        int writes = 0, pulses = 0, reads = 0, overlap = 0, border = 0, hold_bad = 0;
        int t = 0, finish_t = -1, last_t = -2, last_addr = -1;
        fill_random(255);
        for (int y = y0; y <= LAST; y++)
            for (int x = 1; x <= LAST; x++) begin
                exp_q.push_back(y * IMG_W + x);
                exp_total += slides(x) ? 6 : 12;
                exp_reads += slides(x) ? 3 : 9;
                n++;
            end
        apply_reset();
        start_at(y0, 1);
        while (finish_t < 0 && t < exp_total + 200) begin
            if (bus.finish) finish_t = t;
            else begin
                if (bus.gray_req) reads++;
                if (bus.cnt_en) pulses++;
                if (bus.gray_req && bus.lbp_valid) overlap++;
                if (bus.lbp_valid) begin
                    int a, ea;
                    a  = int'(bus.lbp_addr);
                    ea = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    writes++; last_t = t; last_addr = a;
                    if (a / IMG_W < 1 || a / IMG_W > LAST || a % IMG_W < 1 || a % IMG_W > LAST) border++;
                    checks++;
                    if (a != ea) begin errors++; $display("FAIL frame_addr #%0d: got %0d want %0d", writes, a, ea); end
                    else begin
                        checks++;
                        if (bus.lbp_data !== ref_code(a)) begin errors++; $display("FAIL frame_code @%0d: got %h want %h", a, bus.lbp_data, ref_code(a)); end
                    end
                end
            end
            @(negedge clk);
            t++;
        end
        repeat (20) begin
            if (!bus.finish || bus.gray_req || bus.lbp_valid || bus.cnt_en) hold_bad++;
            @(negedge clk);
        end
        checks++;
        if (finish_t != exp_total) begin errors++; $display("FAIL frame_finish_time: got %0d want %0d", finish_t, exp_total); end
        checks++;
        if (writes != n) begin errors++; $display("FAIL frame_writes: got %0d want %0d", writes, n); end
        checks++;
        if (pulses != n - 1) begin errors++; $display("FAIL frame_cnt_en: got %0d want %0d", pulses, n - 1); end
        checks++;
        if (reads != exp_reads) begin errors++; $display("FAIL frame_reads: got %0d want %0d", reads, exp_reads); end
        checks++;
        if (overlap != 0 || border != 0) begin errors++; $display("FAIL frame_overlap_border: got %0d/%0d want 0/0", overlap, border); end
        checks++;
        if (last_addr != LAST * IMG_W + LAST || finish_t != last_t + 1) begin
            errors++; $display("FAIL frame_last_write: got addr=%0d gap=%0d want addr=%0d gap=1", last_addr, finish_t - last_t, LAST * IMG_W + LAST);
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL finish_hold: bad cycles=%0d want 0", hold_bad); end
    endtask

    initial begin
        bus.gray_ready = 1'b0;
        test_reset();
        test_first_centre();
        test_patterns();
        test_reset_mid();
        test_full_frame(121);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
